// File: rtl/cache_controller_nway.sv
// cache_controller_nway
//   N-way set-associative cache controller. Holds tag/valid/dirty and
//   round-robin replacement state; the line data lives in an external array
//   driven through the cache_mem_* port. WRITE_BACK selects write-back +
//   write-allocate (1) or write-through + no-write-allocate (0). A flush walks
//   every (set, way), writes back dirty lines and invalidates everything.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   cpu_addr/wdata      request address (bits [1:0] ignored) and write word
//   cpu_read/write      request strobes, sampled in IDLE only; both high = read
//   cpu_flush           flush request, sampled in IDLE, wins over read/write
//   cpu_rdata/hit/ready completion: one-cycle ready pulse with read word and hit
//   cache_mem_*         data array: index/way select, write line, write enable,
//                       combinational read of the selected line
//   main_mem_*          memory: line read, line write or single-word write;
//                       the request is held until main_mem_ready is seen
module cache_controller_nway #(
    parameter int ADDR_W      = 32,
    parameter int WAYS        = 2,
    parameter int SETS        = 64,
    parameter int BLOCK_BYTES = 64,
    parameter int WRITE_BACK  = 1,
    localparam int OFF_W = $clog2(BLOCK_BYTES),
    localparam int IDX_W = $clog2(SETS),
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W,
    localparam int BLK_W = 8 * BLOCK_BYTES,
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic              cpu_flush,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_hit,
    output logic              cpu_ready,
    output logic [IDX_W-1:0]  cache_mem_index,
    output logic [WAY_W-1:0]  cache_mem_way,
    output logic [BLK_W-1:0]  cache_mem_data_in,
    output logic              cache_mem_write_en,
    input  logic [BLK_W-1:0]  cache_mem_data_out,
    output logic [ADDR_W-1:0] main_mem_addr,
    output logic [BLK_W-1:0]  main_mem_wdata,
    output logic              main_mem_read_req,
    output logic              main_mem_write_req,
    output logic              main_mem_word,
    input  logic [BLK_W-1:0]  main_mem_rdata,
    input  logic              main_mem_ready
);
    localparam int WSEL_W = OFF_W - 2;

    typedef enum logic [3:0] {
        IDLE, LOOKUP, EVICT, FILL, MERGE, WT_WORD, FLUSH_SCAN, FLUSH_WB, RESP
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0]         addr_q;
    logic [31:0]               wdata_q;
    logic [31:0]               rdata_q;
    logic                      wr_q;
    logic                      hit_q;
    logic [WAY_W-1:0]          way_q;     // hit way or chosen victim
    logic [IDX_W-1:0]          fset_q;    // flush cursor
    logic [WAY_W-1:0]          fway_q;
    logic [SETS-1:0][WAYS-1:0] valid_q;
    logic [SETS-1:0][WAYS-1:0] dirty_q;
    logic [SETS-1:0][WAY_W-1:0] rr_q;
    logic [TAG_W-1:0]          tag_q [SETS][WAYS];

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [WSEL_W-1:0] req_wsel;
    assign req_tag  = addr_q[ADDR_W-1 -: TAG_W];
    assign req_idx  = addr_q[OFF_W +: IDX_W];
    assign req_wsel = addr_q[2 +: WSEL_W];

    function automatic logic [BLK_W-1:0] merge_word(input logic [BLK_W-1:0] line,
                                                    input logic [WSEL_W-1:0] sel,
                                                    input logic [31:0] w);
        logic [BLK_W-1:0] r;
        r = line;
        r[32*int'(sel) +: 32] = w;
        return r;
    endfunction

    function automatic logic [31:0] get_word(input logic [BLK_W-1:0] line,
                                             input logic [WSEL_W-1:0] sel);
        return line[32*int'(sel) +: 32];
    endfunction

    // Tag compare across all ways; victim is the lowest invalid way, falling
    // back to the set's round-robin pointer when the set is full.
    logic             look_hit;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] victim;

    always_comb begin
        look_hit = 1'b0;
        hit_way  = '0;
        victim   = rr_q[req_idx];
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                look_hit = 1'b1;
                hit_way  = WAY_W'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[req_idx][w]) victim = WAY_W'(w);
        end
    end

    logic [WAY_W-1:0] rr_next;
    assign rr_next = (rr_q[req_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[req_idx] + 1'b1;

    logic             flush_last;
    logic             flush_dirty;
    logic [IDX_W-1:0] fset_n;
    logic [WAY_W-1:0] fway_n;
    assign flush_last  = (fset_q == IDX_W'(SETS - 1)) && (fway_q == WAY_W'(WAYS - 1));
    assign flush_dirty = valid_q[fset_q][fway_q] & dirty_q[fset_q][fway_q];

    always_comb begin
        fway_n = fway_q + 1'b1;
        fset_n = fset_q;
        if (fway_q == WAY_W'(WAYS - 1)) begin
            fway_n = '0;
            fset_n = fset_q + 1'b1;
        end
    end

    // Next state and all outputs; every output is 0 in IDLE so an async reset
    // drops memory requests in the same cycle.
    always_comb begin
        state_d            = state_q;
        cpu_rdata          = '0;
        cpu_hit            = 1'b0;
        cpu_ready          = 1'b0;
        cache_mem_index    = '0;
        cache_mem_way      = '0;
        cache_mem_data_in  = '0;
        cache_mem_write_en = 1'b0;
        main_mem_addr      = '0;
        main_mem_wdata     = '0;
        main_mem_read_req  = 1'b0;
        main_mem_write_req = 1'b0;
        main_mem_word      = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_flush)                  state_d = FLUSH_SCAN;
                else if (cpu_read || cpu_write) state_d = LOOKUP;
            end
            LOOKUP: begin
                cache_mem_index = req_idx;
                cache_mem_way   = look_hit ? hit_way : victim;
                if (look_hit) begin
                    if (!wr_q) begin
                        state_d = RESP;
                    end else begin
                        cache_mem_data_in  = merge_word(cache_mem_data_out, req_wsel, wdata_q);
                        cache_mem_write_en = 1'b1;
                        state_d = (WRITE_BACK != 0) ? RESP : WT_WORD;
                    end
                end else if (wr_q && (WRITE_BACK == 0)) begin
                    state_d = WT_WORD;
                end else if (valid_q[req_idx][victim] && dirty_q[req_idx][victim]) begin
                    state_d = EVICT;
                end else begin
                    state_d = FILL;
                end
            end
            EVICT: begin
                cache_mem_index    = req_idx;
                cache_mem_way      = way_q;
                main_mem_addr      = {tag_q[req_idx][way_q], req_idx, {OFF_W{1'b0}}};
                main_mem_wdata     = cache_mem_data_out;
                main_mem_write_req = 1'b1;
                if (main_mem_ready) state_d = FILL;
            end
            FILL: begin
                cache_mem_index   = req_idx;
                cache_mem_way     = way_q;
                main_mem_addr     = {req_tag, req_idx, {OFF_W{1'b0}}};
                main_mem_read_req = 1'b1;
                if (main_mem_ready) begin
                    cache_mem_data_in  = main_mem_rdata;
                    cache_mem_write_en = 1'b1;
                    state_d = wr_q ? MERGE : RESP;
                end
            end
            MERGE: begin
                cache_mem_index    = req_idx;
                cache_mem_way      = way_q;
                cache_mem_data_in  = merge_word(cache_mem_data_out, req_wsel, wdata_q);
                cache_mem_write_en = 1'b1;
                state_d            = RESP;
            end
            WT_WORD: begin
                main_mem_addr      = addr_q;
                main_mem_wdata     = {{(BLK_W - 32){1'b0}}, wdata_q};
                main_mem_write_req = 1'b1;
                main_mem_word      = 1'b1;
                if (main_mem_ready) state_d = RESP;
            end
            FLUSH_SCAN: begin
                cache_mem_index = fset_q;
                cache_mem_way   = fway_q;
                if (flush_dirty)     state_d = FLUSH_WB;
                else if (flush_last) state_d = RESP;
            end
            FLUSH_WB: begin
                cache_mem_index    = fset_q;
                cache_mem_way      = fway_q;
                main_mem_addr      = {tag_q[fset_q][fway_q], fset_q, {OFF_W{1'b0}}};
                main_mem_wdata     = cache_mem_data_out;
                main_mem_write_req = 1'b1;
                if (main_mem_ready) state_d = flush_last ? RESP : FLUSH_SCAN;
            end
            RESP: begin
                cpu_ready = 1'b1;
                cpu_rdata = rdata_q;
                cpu_hit   = hit_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wr_q    <= 1'b0;
            hit_q   <= 1'b0;
            way_q   <= '0;
            fset_q  <= '0;
            fway_q  <= '0;
            valid_q <= '0;
            dirty_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (cpu_flush) begin
                        fset_q <= '0;
                        fway_q <= '0;
                        hit_q  <= 1'b0;
                    end else if (cpu_read || cpu_write) begin
                        addr_q  <= cpu_addr;
                        wdata_q <= cpu_wdata;
                        wr_q    <= cpu_write & ~cpu_read;
                    end
                end
                LOOKUP: begin
                    hit_q <= look_hit;
                    way_q <= look_hit ? hit_way : victim;
                    if (look_hit && !wr_q)
                        rdata_q <= get_word(cache_mem_data_out, req_wsel);
                    if (look_hit && wr_q && (WRITE_BACK != 0))
                        dirty_q[req_idx][hit_way] <= 1'b1;
                end
                FILL: begin
                    if (main_mem_ready) begin
                        valid_q[req_idx][way_q] <= 1'b1;
                        dirty_q[req_idx][way_q] <= 1'b0;
                        rr_q[req_idx]           <= rr_next;
                        if (!wr_q) rdata_q <= get_word(main_mem_rdata, req_wsel);
                    end
                end
                MERGE: dirty_q[req_idx][way_q] <= 1'b1;
                FLUSH_SCAN: begin
                    if (!flush_dirty) begin
                        valid_q[fset_q][fway_q] <= 1'b0;
                        fset_q <= fset_n;
                        fway_q <= fway_n;
                    end
                end
                FLUSH_WB: begin
                    if (main_mem_ready) begin
                        valid_q[fset_q][fway_q] <= 1'b0;
                        dirty_q[fset_q][fway_q] <= 1'b0;
                        fset_q <= fset_n;
                        fway_q <= fway_n;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tags need no reset: a tag is only trusted while its valid bit is set.
    always_ff @(posedge clk) begin
        if (state_q == FILL && main_mem_ready)
            tag_q[req_idx][way_q] <= req_tag;
    end

endmodule

// File: tb/tb_cache_controller_nway.sv
// Directed bench: instance 0 is write-back, instance 1 write-through, both
// 2-way, 16 sets, 64-byte lines. Each instance has its own data array and a
// main-memory model answering every request two cycles after it appears.
module tb_cache_controller_nway;
    localparam int ADDR_W = 32;
    localparam int WAYS   = 2;
    localparam int SETS   = 16;
    localparam int BB     = 64;
    localparam int BLK_W  = 8 * BB;
    localparam int IDX_W  = 4;
    localparam int WAY_W  = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst = 2'b11;
    logic [31:0] cpu_addr  [2];
    logic [31:0] cpu_wdata [2];
    logic [1:0]  cpu_read  = '0;
    logic [1:0]  cpu_write = '0;
    logic [1:0]  cpu_flush = '0;
    wire  [31:0] cpu_rdata [2];
    wire  [1:0]  cpu_hit;
    wire  [1:0]  cpu_ready;

    wire [31:0]      rd_cnt_a     [2];
    wire [31:0]      wr_cnt_a     [2];
    wire [31:0]      last_rd_a    [2];
    wire [31:0]      last_wr_a    [2];
    wire [31:0]      prev_wr_a    [2];
    wire [BLK_W-1:0] last_wdata_a [2];
    wire [1:0]       last_word_a;
    wire [1:0]       mm_rd_a;
    wire [1:0]       mm_wr_a;
    wire [1:0]       cm_we_a;

    int n_chk = 0;
    int n_err = 0;

    // Default memory contents: word at byte address a is a ^ 0x5A000000,
    // except line 0x1040 whose word2 is 0xDEADBEEF.
    function automatic logic [BLK_W-1:0] dflt(input logic [31:0] base);
        logic [BLK_W-1:0] r;
        for (int k = 0; k < BB / 4; k++) r[32*k +: 32] = (base + 32'(4 * k)) ^ 32'h5A00_0000;
        if (base == 32'h1040) r[95:64] = 32'hDEADBEEF;
        return r;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        logic [IDX_W-1:0]  cm_idx;
        logic [WAY_W-1:0]  cm_way;
        logic [BLK_W-1:0]  cm_din, cm_dout, mm_wdata;
        logic [BLK_W-1:0]  mm_rdata = '0;
        logic              cm_we, mm_rd, mm_wr, mm_word;
        logic              mm_rdy = 1'b0;
        logic [31:0]       mm_addr;
        logic [BLK_W-1:0]  darr [SETS][WAYS];
        logic [BLK_W-1:0]  mem [logic [31:0]];
        int                rd_cnt = 0, wr_cnt = 0, cnt = 0;
        logic [31:0]       last_rd = '0, last_wr = '0, prev_wr = '0;
        logic [BLK_W-1:0]  last_wdata = '0;
        logic              last_word = 1'b0;
        logic [31:0]       base;
        logic [BLK_W-1:0]  line;

        cache_controller_nway #(
            .ADDR_W(ADDR_W), .WAYS(WAYS), .SETS(SETS), .BLOCK_BYTES(BB),
            .WRITE_BACK((g == 0) ? 1 : 0)
        ) u_dut (
            .clk(clk), .rst(rst[g]),
            .cpu_addr(cpu_addr[g]), .cpu_wdata(cpu_wdata[g]),
            .cpu_read(cpu_read[g]), .cpu_write(cpu_write[g]), .cpu_flush(cpu_flush[g]),
            .cpu_rdata(cpu_rdata[g]), .cpu_hit(cpu_hit[g]), .cpu_ready(cpu_ready[g]),
            .cache_mem_index(cm_idx), .cache_mem_way(cm_way),
            .cache_mem_data_in(cm_din), .cache_mem_write_en(cm_we),
            .cache_mem_data_out(cm_dout),
            .main_mem_addr(mm_addr), .main_mem_wdata(mm_wdata),
            .main_mem_read_req(mm_rd), .main_mem_write_req(mm_wr), .main_mem_word(mm_word),
            .main_mem_rdata(mm_rdata), .main_mem_ready(mm_rdy)
        );

        assign cm_dout = darr[cm_idx][cm_way];
        always @(posedge clk) if (cm_we) darr[cm_idx][cm_way] <= cm_din;

        always @(negedge clk) begin
            if (rst[g]) begin
                mm_rdy = 1'b0;
                cnt    = 0;
            end else if (mm_rdy) begin
                mm_rdy = 1'b0;
                cnt    = 0;
            end else if (mm_rd || mm_wr) begin
                cnt++;
                if (cnt >= 2) begin
                    base = {mm_addr[31:6], 6'b0};
                    line = mem.exists(base) ? mem[base] : dflt(base);
                    if (mm_rd) begin
                        mm_rdata = line;
                        rd_cnt++;
                        last_rd = mm_addr;
                    end else begin
                        wr_cnt++;
                        prev_wr    = last_wr;
                        last_wr    = mm_addr;
                        last_wdata = mm_wdata;
                        last_word  = mm_word;
                        if (mm_word) line[32*int'(mm_addr[5:2]) +: 32] = mm_wdata[31:0];
                        else         line = mm_wdata;
                        mem[base] = line;
                    end
                    mm_rdy = 1'b1;
                end
            end
        end

        assign rd_cnt_a[g]     = rd_cnt;
        assign wr_cnt_a[g]     = wr_cnt;
        assign last_rd_a[g]    = last_rd;
        assign last_wr_a[g]    = last_wr;
        assign prev_wr_a[g]    = prev_wr;
        assign last_wdata_a[g] = last_wdata;
        assign last_word_a[g]  = last_word;
        assign mm_rd_a[g]      = mm_rd;
        assign mm_wr_a[g]      = mm_wr;
        assign cm_we_a[g]      = cm_we;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One request: strobe for a single cycle, then wait (bounded) for ready.
    // lat counts falling edges after the strobe cycle until ready is seen.
    task automatic access(input int i, input logic wr, input logic fl,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic h, output int lat);
        @(negedge clk);
        cpu_addr[i]  = a;
        cpu_wdata[i] = d;
        cpu_read[i]  = !wr && !fl;
        cpu_write[i] = wr;
        cpu_flush[i] = fl;
        lat = 0; rd = '0; h = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            cpu_read[i] = 1'b0; cpu_write[i] = 1'b0; cpu_flush[i] = 1'b0;
            if (cpu_ready[i]) begin
                lat = c; rd = cpu_rdata[i]; h = cpu_hit[i];
                break;
            end
        end
        if (lat == 0) check("ready_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        h;
        int          lat;
        int          r0;
        logic        seen;
        for (int i = 0; i < 2; i++) begin cpu_addr[i] = '0; cpu_wdata[i] = '0; end

        repeat (3) @(negedge clk);
        check("rst_ready",  {62'd0, cpu_ready}, 64'd0);
        check("rst_rdreq",  {62'd0, mm_rd_a},   64'd0);
        check("rst_wrreq",  {62'd0, mm_wr_a},   64'd0);
        check("rst_cm_we",  {62'd0, cm_we_a},   64'd0);
        rst = 2'b00;

        // ---------------- write-back instance ----------------
        access(0, 0, 0, 32'h1048, 0, rd, h, lat);
        check("wb_cold_rdata", rd, 32'hDEADBEEF);
        check("wb_cold_hit", h, 0);
        check("wb_cold_rdcnt", rd_cnt_a[0], 1);
        check("wb_cold_rdaddr", last_rd_a[0], 32'h1040);
        access(0, 0, 0, 32'h1048, 0, rd, h, lat);
        check("wb_rehit_rdata", rd, 32'hDEADBEEF);
        check("wb_rehit_hit", h, 1);
        check("wb_rehit_lat", lat, 2);
        check("wb_rehit_rdcnt", rd_cnt_a[0], 1);
        access(0, 1, 0, 32'h1044, 32'h12345678, rd, h, lat);
        check("wb_whit_hit", h, 1);
        check("wb_whit_rdcnt", rd_cnt_a[0], 1);
        check("wb_whit_wrcnt", wr_cnt_a[0], 0);
        access(0, 0, 0, 32'h1044, 0, rd, h, lat);
        check("wb_whit_read", rd, 32'h12345678);
        check("wb_whit_readhit", h, 1);
        // set 1: A=0x1040 (dirty, way0), B=0x1440 (way1), then C=0x1840
        access(0, 0, 0, 32'h1440, 0, rd, h, lat);
        check("wb_b_rdata", rd, 32'h5A001440);
        check("wb_b_hit", h, 0);
        access(0, 0, 0, 32'h1848, 0, rd, h, lat);
        check("wb_c_hit", h, 0);
        check("wb_c_rdata", rd, 32'h5A001848);
        check("wb_evict_wrcnt", wr_cnt_a[0], 1);
        check("wb_evict_addr", last_wr_a[0], 32'h1040);
        check("wb_evict_word", last_word_a[0], 0);
        check("wb_evict_w1", last_wdata_a[0][63:32], 32'h12345678);
        check("wb_evict_w2", last_wdata_a[0][95:64], 32'hDEADBEEF);
        check("wb_c_rdaddr", last_rd_a[0], 32'h1840);
        check("wb_c_rdcnt", rd_cnt_a[0], 3);
        access(0, 0, 0, 32'h1440, 0, rd, h, lat);
        check("wb_b_rehit", h, 1);
        access(0, 0, 0, 32'h1044, 0, rd, h, lat);
        check("wb_a_miss", h, 0);
        check("wb_a_refetch", rd, 32'h12345678);
        check("wb_a_clean_victim", wr_cnt_a[0], 1);
        // write-allocate misses leave dirty lines in sets 3 and 9
        access(0, 1, 0, 32'h20C4, 32'h11112222, rd, h, lat);
        check("wb_wmiss_hit", h, 0);
        check("wb_wmiss_rdcnt", rd_cnt_a[0], 5);
        check("wb_wmiss_wrcnt", wr_cnt_a[0], 1);
        access(0, 0, 0, 32'h20C4, 0, rd, h, lat);
        check("wb_wmiss_read", rd, 32'h11112222);
        check("wb_wmiss_readhit", h, 1);
        access(0, 1, 0, 32'h0240, 32'h33334444, rd, h, lat);
        access(0, 0, 1, 32'h0, 0, rd, h, lat);
        check("wb_flush_hit", h, 0);
        check("wb_flush_wrcnt", wr_cnt_a[0], 3);
        check("wb_flush_first", prev_wr_a[0], 32'h20C0);
        check("wb_flush_second", last_wr_a[0], 32'h0240);
        check("wb_flush_data", last_wdata_a[0][31:0], 32'h33334444);
        access(0, 0, 0, 32'h20C4, 0, rd, h, lat);
        check("wb_postflush_hit", h, 0);
        check("wb_postflush_rdata", rd, 32'h11112222);

        // reset while waiting for the fill
        r0 = rd_cnt_a[0];
        @(negedge clk);
        cpu_addr[0] = 32'h3000; cpu_read[0] = 1'b1;
        @(negedge clk);
        cpu_read[0] = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (mm_rd_a[0]) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        check("rst_fill_reached", seen, 1);
        rst[0] = 1'b1;
        #1;
        check("rst_mid_rdreq", mm_rd_a[0], 0);
        check("rst_mid_ready", cpu_ready[0], 0);
        check("rst_mid_cm_we", cm_we_a[0], 0);
        @(negedge clk);
        #1 rst[0] = 1'b0;
        access(0, 0, 0, 32'h3000, 0, rd, h, lat);
        check("rst_reread_hit", h, 0);
        check("rst_reread_rdcnt", rd_cnt_a[0], r0 + 1);
        access(0, 0, 0, 32'h1440, 0, rd, h, lat);
        check("rst_lost_line", h, 0);

        // ---------------- write-through instance ----------------
        access(1, 0, 0, 32'h1048, 0, rd, h, lat);
        check("wt_cold_rdata", rd, 32'hDEADBEEF);
        check("wt_cold_hit", h, 0);
        access(1, 1, 0, 32'h1044, 32'hCAFEF00D, rd, h, lat);
        check("wt_whit_hit", h, 1);
        check("wt_whit_wrcnt", wr_cnt_a[1], 1);
        check("wt_whit_addr", last_wr_a[1], 32'h1044);
        check("wt_whit_word", last_word_a[1], 1);
        check("wt_whit_data", last_wdata_a[1][31:0], 32'hCAFEF00D);
        check("wt_whit_rdcnt", rd_cnt_a[1], 1);
        access(1, 0, 0, 32'h1044, 0, rd, h, lat);
        check("wt_read_rdata", rd, 32'hCAFEF00D);
        check("wt_read_hit", h, 1);
        check("wt_read_lat", lat, 2);
        access(1, 1, 0, 32'h5004, 32'h0BADF00D, rd, h, lat);
        check("wt_wmiss_hit", h, 0);
        check("wt_wmiss_wrcnt", wr_cnt_a[1], 2);
        check("wt_wmiss_rdcnt", rd_cnt_a[1], 1);
        access(1, 0, 0, 32'h5004, 0, rd, h, lat);
        check("wt_wmiss_readhit", h, 0);
        check("wt_wmiss_rdata", rd, 32'h0BADF00D);
        check("wt_wmiss_rdcnt2", rd_cnt_a[1], 2);
        access(1, 0, 1, 32'h0, 0, rd, h, lat);
        check("wt_flush_lat", lat, SETS * WAYS + 1);
        check("wt_flush_hit", h, 0);
        check("wt_flush_wrcnt", wr_cnt_a[1], 2);
        access(1, 0, 0, 32'h1044, 0, rd, h, lat);
        check("wt_postflush_hit", h, 0);
        check("wt_postflush_rdata", rd, 32'hCAFEF00D);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
